lc3_mem_responder: RTL

//  Parametrised instruction+data memory model answering the LC3 DUT's fetch and memory-access ports.

---
 rtl/lc3_mem_pkg.sv | 15 +
 rtl/lc3_mem_chan_fsm.sv | 73 +++++++
 rtl/lc3_mem_responder.sv | 111 +++++++++++
 3 files changed

// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared types, LFSR constants and index helper for the LC3 memory responder
package lc3_mem_pkg;

   typedef enum logic [1:0] {MEM_IDLE, MEM_BUSY, MEM_RESP} mem_state_t;

   localparam logic [15:0] LFSR_TAPS  = 16'hB400;
   localparam logic [15:0] INSTR_SEED = 16'hACE1;
   localparam logic [15:0] DATA_SEED  = 16'h1D2B;

   // Store index for an address; higher address bits alias back into the store.
   function automatic logic [31:0] mem_idx(input logic [31:0] addr, input int unsigned depth);
      return addr % depth;
   endfunction

endpackage

// File: rtl/lc3_mem_chan_fsm.sv
// rtl/lc3_mem_chan_fsm.sv - one memory channel: accept, wait-state count, commit strobe, complete pulse
// LC3_MEM_RAND_WAIT_EN adds LFSR jitter of 0..3 cycles to the loaded wait count.
module lc3_mem_chan_fsm
   import lc3_mem_pkg::*;
#(
   parameter int WAIT  = 0,
   parameter int PAY_W = 16
`ifdef LC3_MEM_RAND_WAIT_EN
   ,
   parameter logic [15:0] SEED = INSTR_SEED
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic [PAY_W-1:0] payload,
   input  logic             hold,
   output logic             do_access,
   output logic [PAY_W-1:0] acc_payload,
   output logic             complete
);

   mem_state_t state;
   logic [4:0] cnt;
   logic [4:0] cnt_load;

`ifdef LC3_MEM_RAND_WAIT_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr <= SEED;
      else     lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
   end

   assign cnt_load = 5'(WAIT) + {3'b000, lfsr[1:0]};
`else
   assign cnt_load = 5'(WAIT);
`endif

   // Commit edge: the last BUSY cycle, unless the top is holding us off.
   assign do_access = (state == MEM_BUSY) && (cnt == 5'd0) && !hold;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= MEM_IDLE;
         cnt         <= '0;
         acc_payload <= '0;
         complete    <= 1'b0;
      end else begin
         complete <= 1'b0;
         case (state)
            MEM_IDLE: begin
               if (req) begin
                  acc_payload <= payload;
                  cnt         <= cnt_load;
                  state       <= MEM_BUSY;
               end
            end
            MEM_BUSY: begin
               if (cnt != 5'd0) begin
                  cnt <= cnt - 5'd1;
               end else if (!hold) begin
                  state    <= MEM_RESP;
                  complete <= 1'b1;
               end
            end
            MEM_RESP: state <= MEM_IDLE;
            default:  state <= MEM_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/lc3_mem_responder.sv
// rtl/lc3_mem_responder.sv - shared instruction/data store answering LC3 fetch and data ports
// LC3_MEM_RAND_WAIT_EN selects per-channel LFSR seeds for jittered wait states.
module lc3_mem_responder
   import lc3_mem_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 16,
   parameter int DEPTH      = 256,
   parameter int INSTR_WAIT = 0,
   parameter int DATA_WAIT  = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc,
   input  logic              instrmem_rd,
   output logic [DATA_W-1:0] Instr_dout,
   output logic              complete_instr,
   input  logic              data_req,
   input  logic              Data_rd,
   input  logic [ADDR_W-1:0] Data_addr,
   input  logic [DATA_W-1:0] Data_din,
   output logic [DATA_W-1:0] Data_dout,
   output logic              complete_data,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int DPAY_W = 1 + DATA_W + ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              i_do;
   logic [ADDR_W-1:0] i_addr;
   logic              d_do;
   logic [DPAY_W-1:0] d_pay;
   logic              d_rd;
   logic [DATA_W-1:0] d_din;
   logic [ADDR_W-1:0] d_addr;
   logic              d_hold;
   logic [IDX_W-1:0]  i_idx;
   logic [IDX_W-1:0]  d_idx;
   logic [IDX_W-1:0]  l_idx;

   assign d_rd   = d_pay[DPAY_W-1];
   assign d_din  = d_pay[ADDR_W +: DATA_W];
   assign d_addr = d_pay[ADDR_W-1:0];

   assign i_idx = IDX_W'(mem_idx(32'(i_addr), DEPTH));
   assign d_idx = IDX_W'(mem_idx(32'(d_addr), DEPTH));
   assign l_idx = IDX_W'(mem_idx(32'(load_addr), DEPTH));

   // A preload owns the write port; a data write colliding with it waits a cycle.
   assign d_hold = load_en && !d_rd;

   lc3_mem_chan_fsm #(
      .WAIT  (INSTR_WAIT),
      .PAY_W (ADDR_W)
`ifdef LC3_MEM_RAND_WAIT_EN
      ,
      .SEED  (INSTR_SEED)
`endif
   ) u_instr (
      .clk         (clk),
      .rst         (reset),
      .req         (instrmem_rd),
      .payload     (pc),
      .hold        (1'b0),
      .do_access   (i_do),
      .acc_payload (i_addr),
      .complete    (complete_instr)
   );

   lc3_mem_chan_fsm #(
      .WAIT  (DATA_WAIT),
      .PAY_W (DPAY_W)
`ifdef LC3_MEM_RAND_WAIT_EN
      ,
      .SEED  (DATA_SEED)
`endif
   ) u_data (
      .clk         (clk),
      .rst         (reset),
      .req         (data_req),
      .payload     ({Data_rd, Data_din, Data_addr}),
      .hold        (d_hold),
      .do_access   (d_do),
      .acc_payload (d_pay),
      .complete    (complete_data)
   );

   always_ff @(posedge clk) begin
      if (load_en)
         mem[l_idx] <= load_data;
      else if (d_do && !d_rd)
         mem[d_idx] <= d_din;
   end

   // Reads sample the store before any same-edge write lands.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Instr_dout <= '0;
         Data_dout  <= '0;
      end else begin
         if (i_do)         Instr_dout <= mem[i_idx];
         if (d_do && d_rd) Data_dout  <= mem[d_idx];
      end
   end

endmodule
